// File: rtl/operand_pipe_n.sv
// rtl/operand_pipe_n.sv - configurable operand register chain with per-stage enables, valids and taps
module operand_pipe_n #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 2,
    parameter     INPUT_MODE = "DIRECT",
    parameter int CASC_TAP   = 1,
    parameter int TAP_W      = 3,
    localparam int CE_W      = (DEPTH > 0) ? DEPTH : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] cin,
    input  logic             in_sel,
    input  logic             valid_in,
    input  logic [CE_W-1:0]  ce,
    input  logic             sclr,
    input  logic [TAP_W-1:0] mult_tap,
    output logic [WIDTH-1:0] xout,
    output logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] mult_out,
    output logic             valid_out,
    output logic             mult_valid,
    output logic             busy
);

    localparam bit MODE_DIRECT  = (INPUT_MODE == "DIRECT");
    localparam bit MODE_CASCADE = (INPUT_MODE == "CASCADE");
    localparam bit MODE_DYNAMIC = (INPUT_MODE == "DYNAMIC");
    localparam logic [TAP_W-1:0] DEPTH_SEL = TAP_W'(DEPTH);

    // Reject configurations the chain cannot represent
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("operand_pipe_n: WIDTH out of range");
    end
    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
        $error("operand_pipe_n: DEPTH out of range");
    end
    if (CASC_TAP < 0 || CASC_TAP > DEPTH) begin : g_bad_casc
        $error("operand_pipe_n: CASC_TAP out of range");
    end
    if ((1 << TAP_W) <= DEPTH) begin : g_bad_tapw
        $error("operand_pipe_n: TAP_W too narrow for DEPTH");
    end
    if (!(MODE_DIRECT || MODE_CASCADE || MODE_DYNAMIC)) begin : g_bad_mode
        $error("operand_pipe_n: illegal INPUT_MODE");
    end

    // Stage 0 is the selected input; tap arrays expose every stage by index
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] tap_s [DEPTH+1];
    logic [DEPTH:0]   tap_v;
    logic [TAP_W-1:0] tap_sel;

    // Input selection feeding stage 1 and any stage-0 tap
    always_comb begin
        if (MODE_CASCADE) begin
            s0 = cin;
        end else if (MODE_DYNAMIC) begin
            s0 = in_sel ? cin : din;
        end else begin
            s0 = din;
        end
    end

    assign tap_s[0] = s0;
    assign tap_v[0] = valid_in;

    if (DEPTH > 0) begin : g_stages
        logic [WIDTH-1:0] s_q [DEPTH];
        logic [WIDTH-1:0] s_d [DEPTH];
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;

        // Next state: clear wins over enables; each stage loads its predecessor independently
        always_comb begin
            for (int k = 0; k < DEPTH; k++) begin
                s_d[k] = s_q[k];
            end
            v_d = v_q;
            if (sclr) begin
                for (int k = 0; k < DEPTH; k++) begin
                    s_d[k] = '0;
                end
                v_d = '0;
            end else begin
                if (ce[0]) begin
                    s_d[0] = s0;
                    v_d[0] = valid_in;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (ce[k]) begin
                        s_d[k] = s_q[k-1];
                        v_d[k] = v_q[k-1];
                    end
                end
            end
        end

        // Stage registers with asynchronous clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    s_q[k] <= '0;
                end
                v_q <= '0;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    s_q[k] <= s_d[k];
                end
                v_q <= v_d;
            end
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_tap
            assign tap_s[k+1] = s_q[k];
        end
        assign tap_v[DEPTH:1] = v_q;
        assign busy           = |v_q;
    end else begin : g_no_stages
        assign busy = 1'b0;
    end

    assign xout      = tap_s[DEPTH];
    assign valid_out = tap_v[DEPTH];
    assign cout      = tap_s[CASC_TAP];

    // Out-of-range multiplier taps clamp to the last stage
    assign tap_sel = (mult_tap > DEPTH_SEL) ? DEPTH_SEL : mult_tap;

    // Multiplier operand mux, combinational in the tap select
    always_comb begin
        mult_out   = tap_s[0];
        mult_valid = tap_v[0];
        for (int i = 1; i <= DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                mult_out   = tap_s[i];
                mult_valid = tap_v[i];
            end
        end
    end

    // Inputs that some configurations leave unread
    logic unused_sink;
    assign unused_sink = ^{clk, rst, ce, sclr, din, cin, in_sel, tap_sel};

endmodule
